i2c_byte_engine: RTL and testbench
==================================

Name: i2c_byte_engine

Overview:
Bit/byte-level I2C master engine directly downstream of the I2C control-path FSM. Consumes the FSM's start, stop, wen and ren command strobes and generates open-drain SCL/SDA waveforms for START, repeated START, STOP, byte write with ACK check, and byte read with ACK/NACK. Reports completion with a one-cycle done pulse so the FSM can step to its next state.

Parameters:
CLK_DIV, 125, clk cycles per quarter SCL period (50 MHz / (4*125) = 100 kHz SCL); legal range 2..65535

Ports:
clk  input  1  system clock (CLOCK_50 domain)
resetn  input  1  synchronous, active-low reset
start  input  1  command: generate START or repeated START
stop  input  1  command: generate STOP
wen  input  1  command: write tx_byte, then sample slave ACK
ren  input  1  command: read one byte, then send ACK/NACK
tx_byte  input  8  byte to write; sampled on command accept
rd_nack  input  1  1 = master NACKs after a read (last byte); sampled on accept
rx_byte  output  8  last byte read, MSB first
ack_err  output  1  1 = slave NACKed the last write; valid from done, held until next wen accept
busy  output  1  command in progress
done  output  1  one-cycle pulse on command completion
scl_oe  output  1  1 = pull SCL low; 0 = release
sda_oe  output  1  1 = pull SDA low; 0 = release
scl_in  input  1  SCL pin readback
sda_in  input  1  SDA pin readback

Behaviour:
- Single clock clk; reset synchronous, active-low on resetn. Reset values: scl_oe=0, sda_oe=0, busy=0, done=0, rx_byte=0, ack_err=0; state IDLE; quarter counter 0.
- Quarter tick: counter runs 0..CLK_DIV-1 only while busy. Tick fires when count==CLK_DIV-1. Counter clears on command accept, so every quarter lasts exactly CLK_DIV cycles.
- Accept: only in IDLE (busy=0). Priority when several strobes are high: start > stop > wen > ren; the others are dropped. busy rises the cycle after accept. Strobes while busy are ignored.
- States: IDLE, START, STOP, WBIT, WACK, RBIT, RACK. Each bit is four quarters q0..q3.
- START: q0 sda_oe=0, scl_oe=1; q1 scl_oe=0; q2 sda_oe=1 (SCL high); q3 scl_oe=1. Works from idle or mid-transaction (repeated START).
- STOP: q0 sda_oe=1, scl_oe=1; q1 scl_oe=0; q2 sda_oe=0; q3 hold. Bus ends fully released.
- WBIT x8, MSB first: q0 scl_oe=1, sda_oe=~bit; q1 scl_oe=0; q2 hold; q3 scl_oe=1.
- WACK: same timing with sda_oe=0. sda_in is sampled at the q2 tick; ack_err = sample.
- RBIT x8: sda_oe=0; sda_in is sampled at the q2 tick and shifted into rx_byte LSB. rx_byte shifts in place.
- RACK: sda_oe = ~rd_nack (latched).
- Outside START/STOP, scl_oe=1 at the end of every command, so SCL is held low between bytes.
- done: asserted the cycle after the final q3 tick; busy falls in that same cycle. A new command may be accepted during the done cycle.
- Latency from accept to done: START/STOP 4*CLK_DIV+1 cycles; wen/ren 36*CLK_DIV+1 cycles.
- Reset mid-operation: on the next edge both lines are released and all outputs return to reset values. No STOP is emitted.

Optional Feature:
CLOCK_STRETCH_EN: when defined, in q1 and q2 the quarter counter freezes while scl_oe=0 and scl_in=0 (slave stretching). Timing resumes when SCL reads high. When not defined, scl_in is ignored and timing is purely counter-based.

Test Plan:
- CLK_DIV=4, start pulse from idle -> SDA falls while SCL high at q2; done exactly 17 cycles after accept; scl_oe=1 at end.
- wen, tx_byte=0xA5, slave model ACKs -> SDA bits 1,0,1,0,0,1,0,1 stable while SCL high; ack_err=0; done at 145 cycles.
- wen, tx_byte=0x3C, slave releases SDA on ACK -> ack_err=1; start/stop/ren accepts leave it at 1; the next wen accept clears it.
- ren, rd_nack=1, slave drives 0xC3 -> rx_byte=0xC3; sda_oe=0 during 9th bit. Repeat with rd_nack=0 -> sda_oe=1 during 9th bit.
- start, stop and wen asserted together while idle -> only START runs. wen pulse while busy -> ignored, no extra done.
- resetn=0 during bit 4 of a write -> next cycle scl_oe=0, sda_oe=0, busy=0. With CLOCK_STRETCH_EN, scl_in held low 10 cycles in q1 -> done delayed by 10 cycles.

Source files
------------

// File: rtl/i2c_byte_engine.sv
// I2C master bit/byte engine: START, STOP, byte write with ACK check and byte read with ACK/NACK.
// Optional slave clock stretching is enabled by defining CLOCK_STRETCH_EN.
module i2c_byte_engine #(
  parameter int CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       stop,
  input  logic       wen,
  input  logic       ren,
  input  logic [7:0] tx_byte,
  input  logic       rd_nack,
  output logic [7:0] rx_byte,
  output logic       ack_err,
  output logic       busy,
  output logic       done,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_in,
  input  logic       sda_in
);

  typedef enum logic [2:0] {IDLE, START, STOP, WBIT, WACK, RBIT, RACK} state_t;

  localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);

  state_t      state, state_nxt;
  logic [1:0]  q, q_nxt;
  logic [2:0]  bcnt, bcnt_nxt;
  logic [15:0] cnt;
  logic [7:0]  tx_reg, tx_src;
  logic        nack_reg;
  logic        accept, tick, freeze, done_nxt;
  logic        scl_nxt, sda_nxt, wbit;

`ifdef CLOCK_STRETCH_EN
  assign freeze = (q == 2'd1 || q == 2'd2) && !scl_oe && !scl_in;
`else
  logic unused_scl_in;
  assign unused_scl_in = scl_in;
  assign freeze = 1'b0;
`endif

  assign accept = (state == IDLE) && (start || stop || wen || ren);
  assign tick   = (state != IDLE) && !freeze && (cnt == DIV_M1);

  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    bcnt_nxt  = bcnt;
    done_nxt  = 1'b0;
    if (accept) begin
      q_nxt    = '0;
      bcnt_nxt = '0;
      if (start)     state_nxt = START;
      else if (stop) state_nxt = STOP;
      else if (wen)  state_nxt = WBIT;
      else           state_nxt = RBIT;
    end else if (tick) begin
      q_nxt = q + 2'd1;
      if (q == 2'd3) begin
        case (state)
          WBIT, RBIT: begin
            if (bcnt == 3'd7) state_nxt = (state == WBIT) ? WACK : RACK;
            else              bcnt_nxt  = bcnt + 3'd1;
          end
          default: begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        endcase
      end
    end
  end

  // Line levels are registered from the upcoming (state, quarter); IDLE holds the last levels.
  always_comb begin
    tx_src  = accept ? tx_byte : tx_reg;
    wbit    = tx_src[3'd7 - bcnt_nxt];
    scl_nxt = scl_oe;
    sda_nxt = sda_oe;
    case (state_nxt)
      START: begin
        sda_nxt = (q_nxt >= 2'd2);
        scl_nxt = (q_nxt == 2'd0) || (q_nxt == 2'd3);
      end
      STOP: begin
        sda_nxt = (q_nxt <= 2'd1);
        scl_nxt = (q_nxt == 2'd0);
      end
      WBIT: begin
        sda_nxt = ~wbit;
        scl_nxt = (q_nxt == 2'd0) || (q_nxt == 2'd3);
      end
      WACK, RBIT: begin
        sda_nxt = 1'b0;
        scl_nxt = (q_nxt == 2'd0) || (q_nxt == 2'd3);
      end
      RACK: begin
        sda_nxt = ~nack_reg;
        scl_nxt = (q_nxt == 2'd0) || (q_nxt == 2'd3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      q        <= '0;
      bcnt     <= '0;
      cnt      <= '0;
      tx_reg   <= '0;
      nack_reg <= 1'b0;
      scl_oe   <= 1'b0;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_byte  <= '0;
      ack_err  <= 1'b0;
    end else begin
      state  <= state_nxt;
      q      <= q_nxt;
      bcnt   <= bcnt_nxt;
      scl_oe <= scl_nxt;
      sda_oe <= sda_nxt;
      busy   <= (state_nxt != IDLE);
      done   <= done_nxt;
      if (accept || tick)
        cnt <= '0;
      else if (state != IDLE && !freeze)
        cnt <= cnt + 16'd1;
      if (accept) begin
        tx_reg   <= tx_byte;
        nack_reg <= rd_nack;
      end
      if (accept && state_nxt == WBIT)
        ack_err <= 1'b0;
      if (tick && q == 2'd2) begin
        if (state == WACK) ack_err <= sda_in;
        if (state == RBIT) rx_byte <= {rx_byte[6:0], sda_in};
      end
    end
  end

endmodule

// File: tb/tb_i2c_byte_engine.sv
// Scoreboard bench for i2c_byte_engine with an open-drain bus and a simple slave model.
// Stretch scenario runs only when CLOCK_STRETCH_EN is defined.
module tb_i2c_byte_engine;

  typedef struct {
    string      name;
    int         acc;
    int         lat;
    logic       scl;
    logic       sda;
    logic       ack;
    logic [7:0] rx;
    logic [8:0] cap;
    logic       chk_cap;
    int         starts;
    int         stops;
  } exp_t;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start, stop, wen, ren, rd_nack;
  logic [7:0] tx_byte;
  logic [7:0] rx_byte;
  logic       ack_err, busy, done, scl_oe, sda_oe, scl_in, sda_in;

  logic       slv_low = 1'b0;
  logic       slv_scl_low = 1'b0;
  int         slv_mode = 0;
  logic [7:0] slv_data = 8'h00;
  logic       slv_ack = 1'b1;

  int         rises = 0;
  logic [8:0] cap = '0;
  int         starts = 0;
  int         stops = 0;
  logic       busy_prev = 1'b0;
  logic       scl_prev = 1'b1;
  logic       sda_prev = 1'b1;

  int         cyc = 0;
  int         checks = 0;
  int         passes = 0;
  exp_t       sb[$];
  exp_t       e;

  assign scl_in = ~(scl_oe | slv_scl_low);
  assign sda_in = ~(sda_oe | slv_low);

  i2c_byte_engine #(.CLK_DIV(4)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .start   (start),
    .stop    (stop),
    .wen     (wen),
    .ren     (ren),
    .tx_byte (tx_byte),
    .rd_nack (rd_nack),
    .rx_byte (rx_byte),
    .ack_err (ack_err),
    .busy    (busy),
    .done    (done),
    .scl_oe  (scl_oe),
    .sda_oe  (sda_oe),
    .scl_in  (scl_in),
    .sda_in  (sda_in)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
  endtask

  function automatic exp_t mk(input string nm, input int lat, input logic scl, input logic sda,
                              input logic ack, input logic [7:0] rx, input logic [8:0] cp,
                              input logic chk_cp, input int st, input int sp);
    exp_t r;
    r.name = nm; r.acc = 0; r.lat = lat; r.scl = scl; r.sda = sda; r.ack = ack;
    r.rx = rx; r.cap = cp; r.chk_cap = chk_cp; r.starts = st; r.stops = sp;
    return r;
  endfunction

  // Slave: samples the bus 2 time units after each edge, drives SDA only while SCL is low.
  always @(posedge clk) begin
    logic cur_scl, cur_sda;
    logic [2:0] bi;
    #2;
    cur_scl = scl_in;
    cur_sda = sda_in;
    if (busy && !busy_prev) begin
      rises = 0; cap = '0; starts = 0; stops = 0;
    end
    busy_prev = busy;
    if (cur_scl && scl_prev && sda_prev && !cur_sda) starts++;
    if (cur_scl && scl_prev && !sda_prev && cur_sda) stops++;
    if (busy && cur_scl && !scl_prev) begin
      if (rises < 9) cap = {cap[7:0], cur_sda};
      rises++;
    end
    scl_prev = cur_scl;
    sda_prev = cur_sda;
    if (!busy) slv_low = 1'b0;
    else if (!cur_scl) begin
      bi = 3'(7 - rises);
      case (slv_mode)
        1: slv_low = (rises == 8) && slv_ack;
        2: slv_low = (rises < 8) ? ~slv_data[bi] : 1'b0;
        default: slv_low = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (resetn && done === 1'b1) begin
      if (sb.size() == 0) chk("spurious_done", 32'(done), 32'd0);
      else begin
        e = sb.pop_front();
        chk({e.name, "_lat"},    cyc - e.acc, e.lat);
        chk({e.name, "_scl_oe"}, 32'(scl_oe), 32'(e.scl));
        chk({e.name, "_sda_oe"}, 32'(sda_oe), 32'(e.sda));
        chk({e.name, "_busy"},   32'(busy), 32'd0);
        chk({e.name, "_ack_err"}, 32'(ack_err), 32'(e.ack));
        chk({e.name, "_rx_byte"}, 32'(rx_byte), 32'(e.rx));
        chk({e.name, "_starts"}, starts, e.starts);
        chk({e.name, "_stops"},  stops, e.stops);
        if (e.chk_cap) chk({e.name, "_bus_bits"}, 32'(cap), 32'(e.cap));
      end
    end
  end

  task automatic issue(input logic s, input logic p, input logic w, input logic r,
                       input logic [7:0] tx, input logic nk, input int mode,
                       input logic [7:0] sdata, input logic sack, input logic push, input exp_t ex);
    exp_t x;
    slv_mode = mode; slv_data = sdata; slv_ack = sack;
    start = s; stop = p; wen = w; ren = r; tx_byte = tx; rd_nack = nk;
    x = ex;
    x.acc = cyc;
    if (push) sb.push_back(x);
    @(negedge clk);
    start = 1'b0; stop = 1'b0; wen = 1'b0; ren = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      $display("FAIL %s_timeout: done not seen within 2000 cycles", nm);
    end
  endtask

  initial begin
    exp_t none;
    none = mk("none", 0, 0, 0, 0, 8'h00, 9'h000, 0, 0, 0);
    resetn = 1'b0;
    start = 1'b0; stop = 1'b0; wen = 1'b0; ren = 1'b0; tx_byte = 8'h00; rd_nack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_scl_oe", 32'(scl_oe), 32'd0);
    chk("rst_sda_oe", 32'(sda_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rx_byte", 32'(rx_byte), 32'd0);
    chk("rst_ack_err", 32'(ack_err), 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    issue(1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 1, mk("start_idle", 17, 1, 1, 0, 8'h00, 9'h000, 0, 1, 0));
    wait_done("start_idle");
    issue(0, 0, 1, 0, 8'hA5, 0, 1, 8'h00, 1, 1, mk("wr_a5", 145, 1, 0, 0, 8'h00, 9'h14A, 1, 0, 0));
    wait_done("wr_a5");
    issue(0, 0, 1, 0, 8'h3C, 0, 1, 8'h00, 0, 1, mk("wr_3c_nack", 145, 1, 0, 1, 8'h00, 9'h079, 1, 0, 0));
    wait_done("wr_3c_nack");
    issue(1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 1, mk("rstart", 17, 1, 1, 1, 8'h00, 9'h000, 0, 1, 0));
    wait_done("rstart");
    issue(0, 0, 0, 1, 8'h00, 1, 2, 8'hC3, 1, 1, mk("rd_c3_nack", 145, 1, 0, 1, 8'hC3, 9'h187, 1, 0, 0));
    wait_done("rd_c3_nack");
    issue(0, 0, 0, 1, 8'h00, 0, 2, 8'h5A, 1, 1, mk("rd_5a_ack", 145, 1, 1, 1, 8'h5A, 9'h0B4, 1, 0, 0));
    wait_done("rd_5a_ack");
    issue(0, 1, 0, 0, 8'h00, 0, 0, 8'h00, 1, 1, mk("stop", 17, 0, 0, 1, 8'h5A, 9'h000, 0, 0, 1));
    wait_done("stop");

    // start, stop and wen together: only START runs; a wen while busy is dropped
    issue(1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 1, 1, mk("prio_start", 17, 1, 1, 1, 8'h5A, 9'h000, 0, 1, 0));
    repeat (4) @(negedge clk);
    wen = 1'b1; tx_byte = 8'hFF;
    @(negedge clk);
    wen = 1'b0;
    wait_done("prio_start");
    issue(0, 0, 1, 0, 8'h81, 0, 1, 8'h00, 1, 1, mk("wr_81", 145, 1, 0, 0, 8'h5A, 9'h102, 1, 0, 0));
    wait_done("wr_81");
    issue(0, 1, 0, 0, 8'h00, 0, 0, 8'h00, 1, 1, mk("stop2", 17, 0, 0, 0, 8'h5A, 9'h000, 0, 0, 1));
    wait_done("stop2");

    // reset during bit 4 (q0) of a write of 0x00
    issue(0, 0, 1, 0, 8'h00, 0, 1, 8'h00, 1, 0, none);
    repeat (65) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_scl_oe", 32'(scl_oe), 32'd1);
    chk("pre_rst_sda_oe", 32'(sda_oe), 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    chk("midrst_scl_oe", 32'(scl_oe), 32'd0);
    chk("midrst_sda_oe", 32'(sda_oe), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_rx_byte", 32'(rx_byte), 32'd0);
    chk("midrst_ack_err", 32'(ack_err), 32'd0);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    issue(1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 1, mk("start_after_rst", 17, 1, 1, 0, 8'h00, 9'h000, 0, 1, 0));
    wait_done("start_after_rst");

`ifdef CLOCK_STRETCH_EN
    // slave holds SCL low for 10 cycles in q1 of a START
    issue(1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 1, mk("stretch_start", 27, 1, 1, 0, 8'h00, 9'h000, 0, 1, 0));
    repeat (3) @(negedge clk);
    slv_scl_low = 1'b1;
    repeat (10) @(negedge clk);
    slv_scl_low = 1'b0;
    wait_done("stretch_start");
`endif

    repeat (50) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
